// File: rtl/spi_arbiter.sv
// Round-robin arbiter that grants one of NUM_REQ requesters access to a shared
// SPI master. It sequences the chip select setup, the start pulse, the wait for completion (with timeout), the chip select hold and the response.
module spi_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_SLV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [2*NUM_REQ-1:0] req_slave,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [7:0]           resp_data,
  output logic                 resp_err,
  output logic                 m_start,
  output logic [7:0]           m_data_tx,
  output logic [1:0]           m_mode,
  input  logic                 m_done,
  input  logic [7:0]           m_data_rx,
  output logic [NUM_SLV-1:0]   cs_n,
  output logic                 busy
);

  localparam int PW      = $clog2(NUM_REQ);
  localparam int SETUP_N = (CS_SETUP < 1) ? 1 : CS_SETUP;
  localparam int HOLD_N  = (CS_HOLD  < 1) ? 1 : CS_HOLD;
  localparam int TO_N    = (TIMEOUT  < 1) ? 1 : TIMEOUT;
  localparam int SH_MAX  = (SETUP_N > HOLD_N) ? SETUP_N : HOLD_N;
  localparam int CMAX    = (TO_N > SH_MAX) ? TO_N : SH_MAX;
  localparam int CW      = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT,
    HOLD,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [1:0]           slave_q, slave_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
  logic [7:0]           m_data_tx_q, m_data_tx_d;
  logic [1:0]           m_mode_q, m_mode_d;
  logic [7:0]           resp_data_q, resp_data_d;
  logic                 resp_err_q, resp_err_d;

  logic [PW-1:0]        cand;
  logic [PW-1:0]        gnt_idx;
  logic                 found;

  // First requesting index at or after rr_ptr, wrapping around
  always_comb begin
    cand    = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    slave_d     = slave_q;
    cnt_d       = cnt_q;
    req_ack_d   = '0;
    m_data_tx_d = m_data_tx_q;
    m_mode_d    = m_mode_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d            = gnt_idx;
          slave_d            = req_slave[2*gnt_idx +: 2];
          m_data_tx_d        = req_data[8*gnt_idx +: 8];
          m_mode_d           = req_mode[2*gnt_idx +: 2];
          req_ack_d[gnt_idx] = 1'b1;
          cnt_d              = '0;
          state_d            = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_N - 1)) begin
          cnt_d   = '0;
          state_d = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // m_done is tested first so it beats a timeout expiring in the same cycle
        if (m_done) begin
          resp_data_d = m_data_rx;
          resp_err_d  = 1'b0;
          cnt_d       = '0;
          state_d     = HOLD;
        end else if (cnt_q == CW'(TO_N - 1)) begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
          cnt_d       = '0;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_N - 1)) begin
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        rr_ptr_d = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      slave_q     <= '0;
      cnt_q       <= '0;
      req_ack_q   <= '0;
      m_data_tx_q <= '0;
      m_mode_q    <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      slave_q     <= slave_d;
      cnt_q       <= cnt_d;
      req_ack_q   <= req_ack_d;
      m_data_tx_q <= m_data_tx_d;
      m_mode_q    <= m_mode_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Chip select is decoded from state so reset releases it on the very next cycle
  always_comb begin
    cs_n = '1;
    if (state_q == SETUP || state_q == START || state_q == WAIT || state_q == HOLD) begin
      for (int unsigned s = 0; s < NUM_SLV; s++) begin
        if (32'(slave_q) == s) cs_n[s] = 1'b0;
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == RESP) resp_valid[grant_q] = 1'b1;
  end

  assign req_ack   = req_ack_q;
  assign m_start   = (state_q == START);
  assign m_data_tx = m_data_tx_q;
  assign m_mode    = m_mode_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter NUM_SLV, default 4, number of SPI slaves / chip selects (1..4).
REQ-003 The block SHALL have parameter CS_SETUP, default 2, clk cycles from cs_n assert to m_start.
REQ-004 The block SHALL have parameter CS_HOLD, default 2, clk cycles from m_done to cs_n deassert.
REQ-005 The block SHALL have parameter TIMEOUT, default 1024, max clk cycles waiting for m_done.
REQ-006 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 The block SHALL have port reset_n  input  1  reset; reset is synchronous and active-low.
REQ-008 The block SHALL have port req_valid  input  NUM_REQ  per-requester request, level, held until req_ack.
REQ-009 The block SHALL have port req_data  input  8*NUM_REQ  tx byte, requester i at [8i+7:8i].
REQ-010 The block SHALL have port req_slave  input  2*NUM_REQ  target slave index, requester i at [2i+1:2i].
REQ-011 The block SHALL have port req_mode  input  2*NUM_REQ  SPI mode {cpol,cpha}, requester i at [2i+1:2i].
REQ-012 The block SHALL have port req_ack  output  NUM_REQ  one-hot 1-cycle pulse: request accepted.
REQ-013 The block SHALL have port resp_valid  output  NUM_REQ  one-hot 1-cycle pulse: transaction finished.
REQ-014 The block SHALL have port resp_data  output  8  received byte, valid with resp_valid.
REQ-015 The block SHALL have port resp_err  output  1  timeout flag, valid with resp_valid.
REQ-016 The block SHALL have port m_start  output  1  1-cycle start pulse to SPI master.
REQ-017 The block SHALL have port m_data_tx, m_mode  output  8, 2  latched tx byte and mode to master.
REQ-018 The block SHALL have port m_done, m_data_rx  input  1, 8  master completion pulse and received byte.
REQ-019 The block SHALL have port cs_n  output  NUM_SLV  active-low chip selects, at most one low.
REQ-020 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states SHALL be IDLE, SETUP, START, WAIT, HOLD, RESP.
REQ-022 IDLE: when any req_valid high, grant = first index with req_valid at or after rr_ptr (wrapping); next cycle SETUP.
REQ-023 On grant cycle, req_ack[grant] SHALL pulse and req_data/slave/mode of grant SHALL be latched into m_data_tx, cs target, m_mode.
REQ-024 SETUP: cs_n[target] low; stay CS_SETUP cycles (counter), then START; m_mode stable from SETUP entry.
REQ-025 START: m_start high exactly one cycle; next state WAIT.
REQ-026 WAIT: on m_done, latch m_data_rx, resp_err=0, go HOLD; if TIMEOUT cycles elapse without m_done, latch 0x00, resp_err=1, go HOLD.
REQ-027 m_done in the same cycle as timeout expiry SHALL win (resp_err=0).
REQ-028 HOLD: cs_n[target] stays low CS_HOLD cycles, then all cs_n high, go RESP.
REQ-029 RESP: resp_valid[grant] high one cycle with resp_data/resp_err; rr_ptr = (grant+1) mod NUM_REQ; next IDLE.
REQ-030 Minimum turnaround between transactions SHALL be one IDLE cycle; no back-to-back grant from RESP.
REQ-031 req_slave >= NUM_SLV SHALL complete normally with no cs_n asserted.
REQ-032 m_done outside WAIT SHALL be ignored.
REQ-033 req_valid dropping after grant SHALL not affect the transaction in flight.

Reset
REQ-034 With reset_n low at a clk edge: state IDLE, rr_ptr 0, cs_n all 1, m_start 0, req_ack 0, resp_valid 0, resp_data 0x00, resp_err 0, m_data_tx 0x00, m_mode 2'b00, busy 0, counters 0.
REQ-035 Reset mid-transaction SHALL abort it without resp_valid; cs_n high the cycle after the reset edge.

Verification
REQ-036 Single: req_valid=4'b0010, data 0xA5, slave 2, mode 2'b11 -> req_ack[1], cs_n=4'b1011 for CS_SETUP cycles, m_start pulse, m_data_tx=0xA5, m_mode=2'b11; m_done with rx 0x3C -> after CS_HOLD cs_n=4'b1111, resp_valid[1], resp_data 0x3C, resp_err 0.
REQ-037 Round-robin: req_valid=4'b1111 held -> grant order 0,1,2,3,0; each req_ack one-hot.
REQ-038 Timeout: TIMEOUT=16, no m_done -> resp_valid with resp_err 1, resp_data 0x00, cs_n released after CS_HOLD.
REQ-039 Timeout tie: m_done on 16th WAIT cycle -> resp_err 0, resp_data = m_data_rx.
REQ-040 Reset in WAIT: reset_n low one cycle -> no resp_valid, cs_n 4'b1111, rr_ptr 0, next request from requester 3 alone granted normally.
REQ-041 Invalid slave: req_slave=3 with NUM_SLV=2 -> cs_n stays 2'b11, resp_valid still issued.
